// File: rtl/pixel_writer_pkg.sv
// -----------------------------------------------------------------------------
// pixel_writer_pkg
// Definitions shared by every client of an MCB user port:
//   - MCB command instruction codes
//   - default burst size (32-bit words per write command)
//   - FSM state encoding of the write-port client
//   - helper producing the byte mask of a partially filled word
// -----------------------------------------------------------------------------
package pixel_writer_pkg;

    localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
    localparam logic [2:0] MCB_INSTR_READ  = 3'b001;

    localparam int DEFAULT_BURST_WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_CMD  = 2'd2,
        ST_DONE = 2'd3
    } wr_state_e;

    // Mask for a word whose final valid byte sits in 'lane'.
    // Bytes above that lane are not written (mask bit = 1).
    function automatic logic [3:0] last_lane_mask(input logic [1:0] lane);
        return 4'b1110 << lane;
    endfunction

endpackage : pixel_writer_pkg

// File: rtl/pixel_writer_packer.sv
// -----------------------------------------------------------------------------
// pixel_packer
// Packs 8-bit pixels into 32-bit MCB write-FIFO words, first pixel in the
// least-significant byte. A word is pushed the cycle after its fourth pixel
// (or its pix_last pixel) is accepted and is retried while wr_full is high.
//
// Ports
//   clk             clock
//   reset           asynchronous active-low reset
//   clear_i         synchronous discard of any partial/pending word
//   accept_i        a pixel is accepted this cycle
//   pix_data_i      pixel value
//   pix_last_i      accepted pixel is the last of the frame
//   wr_full_i       MCB write FIFO full
//   wr_en_o         write-FIFO push strobe (held while retrying)
//   wr_data_o       packed word
//   wr_mask_o       byte mask, 1 = byte not written
//   push_pending_o  a word is waiting to be pushed
//   push_done_o     the pending word enters the FIFO this cycle
//   push_last_o     the pending word carries the frame's last pixel
// -----------------------------------------------------------------------------
module pixel_packer
    import pixel_writer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  pix_data_i,
    input  logic        pix_last_i,
    input  logic        wr_full_i,
    output logic        wr_en_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_mask_o,
    output logic        push_pending_o,
    output logic        push_done_o,
    output logic        push_last_o
);

    logic [1:0]  lane_q,      lane_d;
    logic [31:0] acc_q,       acc_d;
    logic        wr_en_q,     wr_en_d;
    logic [31:0] wr_data_q,   wr_data_d;
    logic [3:0]  wr_mask_q,   wr_mask_d;
    logic        word_last_q, word_last_d;

    logic [31:0] word_next;
    logic        emit;

    // Accumulator with the incoming pixel dropped into its lane. Lanes above
    // the current one are still zero, which zero-fills a short final word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_next[gi*8 +: 8] = (lane_q == 2'(gi)) ? pix_data_i
                                                         : acc_q[gi*8 +: 8];
    end

    assign emit = accept_i & ((lane_q == 2'd3) | pix_last_i);

    always_comb begin
        lane_d      = lane_q;
        acc_d       = acc_q;
        wr_en_d     = wr_en_q & wr_full_i;   // keep retrying until FIFO has room
        wr_data_d   = wr_data_q;
        wr_mask_d   = wr_mask_q;
        word_last_d = word_last_q;
        if (clear_i) begin
            lane_d  = 2'd0;
            acc_d   = 32'd0;
            wr_en_d = 1'b0;
        end else if (accept_i) begin
            if (emit) begin
                lane_d      = 2'd0;
                acc_d       = 32'd0;
                wr_en_d     = 1'b1;
                wr_data_d   = word_next;
                wr_mask_d   = last_lane_mask(lane_q);
                word_last_d = pix_last_i;
            end else begin
                lane_d = lane_q + 2'd1;
                acc_d  = word_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q      <= 2'd0;
            acc_q       <= 32'd0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 32'd0;
            wr_mask_q   <= 4'd0;
            word_last_q <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_mask_q   <= wr_mask_d;
            word_last_q <= word_last_d;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_data_o      = wr_data_q;
    assign wr_mask_o      = wr_mask_q;
    assign push_pending_o = wr_en_q;
    assign push_done_o    = wr_en_q & ~wr_full_i;
    assign push_last_o    = word_last_q;

endmodule : pixel_packer

// File: rtl/pixel_writer.sv
// -----------------------------------------------------------------------------
// pixel_writer
// Streams 8-bit pixels of a frame into DDR2 through an MCB write port:
// packs 4 pixels per word, issues one WRITE command per burst of up to
// BURST_WORDS words, starting each frame at FRAME_BASE.
//
// Ports
//   clk, reset            clock (MCB port clock) / async active-low reset
//   calib_done            MCB calibration complete
//   pix_data/valid/last   pixel stream in; pix_ready = accepted
//   cmd_en/instr/bl/byte_addr, cmd_full   MCB command port
//   wr_en/data/mask, wr_full              MCB write-data port
//   frame_done            one-cycle pulse after the frame's last command
//   busy                  high outside IDLE
// -----------------------------------------------------------------------------
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int          BURST_WORDS = DEFAULT_BURST_WORDS,
    parameter logic [29:0] FRAME_BASE  = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        calib_done,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    input  logic        wr_full,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [6:0] BURST_CNT = 7'(BURST_WORDS);

    wr_state_e   state_q,      state_d;
    logic [29:0] addr_q,       addr_d;
    logic [6:0]  word_cnt_q,   word_cnt_d;
    logic        last_burst_q, last_burst_d;

    logic accept;
    logic push_pending;
    logic push_done;
    logic push_last;
    logic burst_full;

    assign accept     = pix_valid & pix_ready;
    assign burst_full = (word_cnt_q + 7'd1) == BURST_CNT;

    pixel_packer u_packer (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (state_q == ST_IDLE),
        .accept_i       (accept),
        .pix_data_i     (pix_data),
        .pix_last_i     (pix_last),
        .wr_full_i      (wr_full),
        .wr_en_o        (wr_en),
        .wr_data_o      (wr_data),
        .wr_mask_o      (wr_mask),
        .push_pending_o (push_pending),
        .push_done_o    (push_done),
        .push_last_o    (push_last)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (calib_done) state_d = ST_FILL;
            ST_FILL: begin
                if (push_done && (burst_full || push_last)) begin
                    state_d = ST_CMD;
                end else if (!calib_done && !push_pending && !accept) begin
                    // Calibration lost: flush words already written, if any.
                    state_d = (word_cnt_q != 7'd0) ? ST_CMD : ST_IDLE;
                end
            end
            ST_CMD: begin
                if (!cmd_full) begin
                    if (last_burst_q)     state_d = ST_DONE;
                    else if (!calib_done) state_d = ST_IDLE;
                    else                  state_d = ST_FILL;
                end
            end
            ST_DONE: state_d = calib_done ? ST_FILL : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pix_ready  = 1'b0;
        cmd_en     = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: busy       = 1'b0;
            ST_FILL: pix_ready  = ~wr_full & ~push_pending;
            ST_CMD:  cmd_en     = ~cmd_full;
            ST_DONE: frame_done = 1'b1;
            default: busy       = 1'b0;
        endcase
    end

    // Address / word counter
    always_comb begin
        addr_d       = addr_q;
        word_cnt_d   = word_cnt_q;
        last_burst_d = last_burst_q;
        if (state_q == ST_IDLE || state_q == ST_DONE) begin
            addr_d       = FRAME_BASE;
            word_cnt_d   = 7'd0;
            last_burst_d = 1'b0;
        end else begin
            if (push_done) begin
                word_cnt_d = word_cnt_q + 7'd1;
                if (push_last) last_burst_d = 1'b1;
            end
            if (cmd_en) begin
                // 30-bit add wraps modulo 2^30
                addr_d       = addr_q + {21'd0, word_cnt_q, 2'b00};
                word_cnt_d   = 7'd0;
                last_burst_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= FRAME_BASE;
            word_cnt_q   <= 7'd0;
            last_burst_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            word_cnt_q   <= word_cnt_d;
            last_burst_q <= last_burst_d;
        end
    end

    assign cmd_instr     = MCB_INSTR_WRITE;
    // A count of 64 truncates to 0, and 0 - 1 gives the required 63.
    assign cmd_bl        = word_cnt_q[5:0] - 6'd1;
    assign cmd_byte_addr = addr_q;

endmodule : pixel_writer
